dp_shift_scheduler: RTL and testbench

//  Sequences the two-phase double-pulse generator (p1/p2 latch clocks) in the cba

---
 rtl/dp_shift_scheduler.sv | 158 +++++++++++++++
 tb/tb_dp_shift_scheduler.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dp_shift_scheduler.sv
// Round-robin scheduler sharing the cba shift-chain double-pulse generator
// between the config loader and the readout engine, with pair-safe abort.
module dp_shift_scheduler #(
  parameter int CNT_W = 8,
  parameter int GAP   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_cfg,
  input  logic [CNT_W-1:0] len_cfg,
  output logic             gnt_cfg,
  output logic             done_cfg,
  input  logic             req_rd,
  input  logic [CNT_W-1:0] len_rd,
  output logic             gnt_rd,
  output logic             done_rd,
  input  logic             abort,
  output logic             dp_enable,
  output logic             busy,
  output logic [CNT_W-1:0] pulse_cnt,
  output logic             aborted
);

  typedef enum logic [2:0] {
    S_IDLE, S_GRANT, S_RUN, S_DRAIN, S_DONE, S_GAP
  } state_t;

  localparam int TMR_W = $clog2(GAP + 3);
  localparam logic [TMR_W-1:0] GAP_LAST  = TMR_W'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [TMR_W-1:0] TMR_ONE   = TMR_W'(1);
  localparam logic [CNT_W:0]   ECNT_ONE  = (CNT_W + 1)'(1);
  localparam logic [CNT_W-1:0] PULSE_ONE = CNT_W'(1);

  state_t           state, state_next;
  logic             owner, owner_next;    // 0 = cfg, 1 = rd
  logic             ptr, ptr_next;        // round-robin priority, 0 = cfg
  logic [CNT_W:0]   last_ecnt, last_ecnt_next;
  logic [CNT_W:0]   ecnt, ecnt_next;
  logic             t, t_next;
  logic             dp_enable_next;
  logic [CNT_W-1:0] pulse_cnt_next;
  logic             aborted_next;
  logic             hold, hold_next;
  logic [TMR_W-1:0] tmr, tmr_next;
  logic [CNT_W-1:0] len_sel;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      owner     <= 1'b0;
      ptr       <= 1'b0;
      last_ecnt <= '0;
      ecnt      <= '0;
      t         <= 1'b0;
      dp_enable <= 1'b0;
      pulse_cnt <= '0;
      aborted   <= 1'b0;
      hold      <= 1'b0;
      tmr       <= '0;
    end else begin
      state     <= state_next;
      owner     <= owner_next;
      ptr       <= ptr_next;
      last_ecnt <= last_ecnt_next;
      ecnt      <= ecnt_next;
      t         <= t_next;
      dp_enable <= dp_enable_next;
      pulse_cnt <= pulse_cnt_next;
      aborted   <= aborted_next;
      hold      <= hold_next;
      tmr       <= tmr_next;
    end
  end

  always_comb begin
    state_next     = state;
    owner_next     = owner;
    ptr_next       = ptr;
    last_ecnt_next = last_ecnt;
    ecnt_next      = ecnt;
    t_next         = dp_enable & ~t;
    dp_enable_next = dp_enable;
    pulse_cnt_next = pulse_cnt;
    aborted_next   = aborted;
    hold_next      = hold;
    tmr_next       = tmr;
    len_sel        = owner ? len_rd : len_cfg;

    case (state)
      S_IDLE: begin
        if (req_cfg | req_rd) begin
          owner_next = (req_cfg & req_rd) ? ptr : req_rd;
          ptr_next   = ~owner_next;
          state_next = S_GRANT;
        end
      end
      S_GRANT: begin
        last_ecnt_next = {len_sel, 1'b0} - ECNT_ONE;
        ecnt_next      = ECNT_ONE;
        pulse_cnt_next = '0;
        aborted_next   = 1'b0;
        hold_next      = 1'b0;
        t_next         = 1'b0;
        tmr_next       = '0;
        if (len_sel == '0) begin
          state_next = S_DRAIN;
        end else begin
          state_next     = S_RUN;
          dp_enable_next = 1'b1;
        end
      end
      S_RUN: begin
        // An enable cycle with t=0 launches a new pair, except the abort
        // hold cycle, which only lets the in-flight pair finish.
        if (!t && !hold) pulse_cnt_next = pulse_cnt + PULSE_ONE;
        if (hold) begin
          state_next     = S_DRAIN;
          dp_enable_next = 1'b0;
          aborted_next   = 1'b1;
          hold_next      = 1'b0;
          tmr_next       = '0;
        end else if (ecnt == last_ecnt) begin
          state_next     = S_DRAIN;
          dp_enable_next = 1'b0;
          tmr_next       = '0;
        end else if (abort && !t) begin
          state_next     = S_DRAIN;
          dp_enable_next = 1'b0;
          aborted_next   = 1'b1;
          tmr_next       = '0;
        end else begin
          ecnt_next = ecnt + ECNT_ONE;
          hold_next = abort & t;
        end
      end
      S_DRAIN: begin
        tmr_next = tmr + TMR_ONE;
        if (tmr == TMR_ONE) state_next = S_DONE;
      end
      S_DONE: begin
        tmr_next   = '0;
        state_next = (GAP == 0) ? S_IDLE : S_GAP;
      end
      S_GAP: begin
        tmr_next = tmr + TMR_ONE;
        if (tmr == GAP_LAST) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign gnt_cfg  = (state == S_GRANT) & ~owner;
  assign gnt_rd   = (state == S_GRANT) & owner;
  assign done_cfg = (state == S_DONE) & ~owner;
  assign done_rd  = (state == S_DONE) & owner;
  assign busy     = (state != S_IDLE);

endmodule

// File: tb/tb_dp_shift_scheduler.sv
// Directed bench for dp_shift_scheduler: single, zero-length, round-robin,
// abort, async reset mid-burst and maximum-length bursts.
module tb_dp_shift_scheduler;
  localparam int CNT_W = 8;
  localparam int GAP   = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             req_cfg, req_rd, abort;
  logic [CNT_W-1:0] len_cfg, len_rd;
  logic             gnt_cfg, done_cfg, gnt_rd, done_rd;
  logic             dp_enable, busy, aborted;
  logic [CNT_W-1:0] pulse_cnt;

  int errors = 0;
  int checks = 0;

  // Observations from the most recent run_burst call.
  int   r_gnt_cyc, r_gnt_cnt, r_en_cnt, r_en_first, r_en_last;
  int   r_done_cyc, r_done_cnt, r_idle_cyc;
  logic r_done_ab, r_wrong_gnt, r_timeout, r_busy_drop;

  always #5 clk = ~clk;

  dp_shift_scheduler #(.CNT_W(CNT_W), .GAP(GAP)) dut (
    .clk(clk), .reset(reset),
    .req_cfg(req_cfg), .len_cfg(len_cfg), .gnt_cfg(gnt_cfg), .done_cfg(done_cfg),
    .req_rd(req_rd), .len_rd(len_rd), .gnt_rd(gnt_rd), .done_rd(done_rd),
    .abort(abort), .dp_enable(dp_enable), .busy(busy),
    .pulse_cnt(pulse_cnt), .aborted(aborted)
  );

  // Issues one request (cycle 0) and records what happens, cycle by cycle.
  task automatic run_burst(input logic sel_rd, input logic [CNT_W-1:0] len, input int abort_at);
    r_gnt_cyc = -1; r_gnt_cnt = 0; r_en_cnt = 0; r_en_first = -1; r_en_last = -1;
    r_done_cyc = -1; r_done_cnt = 0; r_idle_cyc = -1;
    r_done_ab = 1'b0; r_wrong_gnt = 1'b0; r_timeout = 1'b1; r_busy_drop = 1'b0;
    @(negedge clk);
    if (sel_rd) begin req_rd = 1'b1; len_rd = len; end
    else begin req_cfg = 1'b1; len_cfg = len; end
    for (int c = 1; c <= 1000; c++) begin
      @(negedge clk);
      abort = 1'b0;
      if (sel_rd ? gnt_rd : gnt_cfg) begin r_gnt_cnt++; r_gnt_cyc = c; end
      if (sel_rd ? (gnt_cfg | done_cfg) : (gnt_rd | done_rd)) r_wrong_gnt = 1'b1;
      if (dp_enable) begin
        r_en_cnt++;
        if (r_en_first < 0) r_en_first = c;
        r_en_last = c;
        if (r_en_cnt == abort_at) abort = 1'b1;
      end
      if (r_gnt_cyc >= 0 && r_done_cyc < 0 && !busy) r_busy_drop = 1'b1;
      if (sel_rd ? done_rd : done_cfg) begin
        r_done_cnt++; r_done_cyc = c; r_done_ab = aborted;
        req_cfg = 1'b0; req_rd = 1'b0;
      end else if (r_done_cyc >= 0 && !busy) begin
        r_idle_cyc = c; r_timeout = 1'b0;
        break;
      end
    end
    abort = 1'b0; req_cfg = 1'b0; req_rd = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; req_cfg = 1'b0; req_rd = 1'b0; abort = 1'b0;
    len_cfg = '0; len_rd = '0;
    @(negedge clk); @(negedge clk);
    checks++;
    if ({gnt_cfg, gnt_rd, done_cfg, done_rd} !== 4'b0000) begin
      errors++; $display("FAIL reset_handshake: got %b expected 0000", {gnt_cfg, gnt_rd, done_cfg, done_rd});
    end
    checks++;
    if ({dp_enable, busy, aborted} !== 3'b000) begin
      errors++; $display("FAIL reset_status: got %b expected 000", {dp_enable, busy, aborted});
    end
    checks++;
    if (pulse_cnt !== 8'd0) begin
      errors++; $display("FAIL reset_pulse_cnt: got %0d expected 0", pulse_cnt);
    end
    reset = 1'b0;
  endtask

  task automatic test_single_burst;
    run_burst(1'b0, 8'd3, 0);
    checks++;
    if (r_timeout !== 1'b0) begin errors++; $display("FAIL single_timeout: burst did not finish"); end
    checks++;
    if (r_gnt_cnt != 1 || r_gnt_cyc != 1) begin
      errors++; $display("FAIL single_grant: got count %0d at cycle %0d expected 1 at cycle 1", r_gnt_cnt, r_gnt_cyc);
    end
    checks++;
    if (r_en_cnt != 5 || r_en_first != 2) begin
      errors++; $display("FAIL single_enable: got %0d cycles from %0d expected 5 from 2", r_en_cnt, r_en_first);
    end
    checks++;
    if (r_done_cnt != 1 || r_done_cyc != r_en_last + 3) begin
      errors++; $display("FAIL single_done: got %0d at cycle %0d expected 1 at cycle %0d", r_done_cnt, r_done_cyc, r_en_last + 3);
    end
    checks++;
    if (pulse_cnt !== 8'd3 || r_done_ab !== 1'b0) begin
      errors++; $display("FAIL single_count: got pulse_cnt %0d aborted %b expected 3 0", pulse_cnt, r_done_ab);
    end
    checks++;
    if (r_idle_cyc != r_done_cyc + GAP + 1 || r_busy_drop !== 1'b0) begin
      errors++; $display("FAIL single_busy: got idle at %0d drop %b expected %0d 0", r_idle_cyc, r_busy_drop, r_done_cyc + GAP + 1);
    end
    checks++;
    if (r_wrong_gnt !== 1'b0) begin errors++; $display("FAIL single_other_side: got 1 expected 0"); end
  endtask

  task automatic test_zero_len;
    run_burst(1'b1, 8'd0, 0);
    checks++;
    if (r_timeout !== 1'b0 || r_gnt_cnt != 1) begin
      errors++; $display("FAIL zero_grant: got timeout %b grants %0d expected 0 1", r_timeout, r_gnt_cnt);
    end
    checks++;
    if (r_en_cnt != 0) begin errors++; $display("FAIL zero_enable: got %0d cycles expected 0", r_en_cnt); end
    checks++;
    if (r_done_cyc != r_gnt_cyc + 3) begin
      errors++; $display("FAIL zero_done: got cycle %0d expected %0d", r_done_cyc, r_gnt_cyc + 3);
    end
    checks++;
    if (pulse_cnt !== 8'd0 || r_wrong_gnt !== 1'b0) begin
      errors++; $display("FAIL zero_count: got pulse_cnt %0d wrong %b expected 0 0", pulse_cnt, r_wrong_gnt);
    end
  endtask

  task automatic test_round_robin;
    int seq[4];
    int exp_seq[4];
    int n_gnt = 0, n_done = 0, en_total = 0, last_hi = -1, min_gap = 1000;
    logic prev_en = 1'b0, finished = 1'b0;
    exp_seq[0] = 0; exp_seq[1] = 1; exp_seq[2] = 0; exp_seq[3] = 1;
    for (int i = 0; i < 4; i++) seq[i] = -1;
    @(negedge clk);
    req_cfg = 1'b1; req_rd = 1'b1; len_cfg = 8'd1; len_rd = 8'd1;
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      if (gnt_cfg) begin if (n_gnt < 4) seq[n_gnt] = 0; n_gnt++; end
      if (gnt_rd)  begin if (n_gnt < 4) seq[n_gnt] = 1; n_gnt++; end
      if (dp_enable) begin
        if (!prev_en && last_hi >= 0 && (c - last_hi - 1) < min_gap) min_gap = c - last_hi - 1;
        last_hi = c; en_total++;
      end
      prev_en = dp_enable;
      if (done_cfg | done_rd) begin
        n_done++;
        if (n_done == 4) begin req_cfg = 1'b0; req_rd = 1'b0; end
      end else if (n_done == 4 && !busy) begin
        finished = 1'b1;
        break;
      end
    end
    req_cfg = 1'b0; req_rd = 1'b0;
    checks++;
    if (finished !== 1'b1 || n_gnt != 4) begin
      errors++; $display("FAIL rr_grants: got finished %b grants %0d expected 1 4", finished, n_gnt);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (seq[i] != exp_seq[i]) begin
        errors++; $display("FAIL rr_order[%0d]: got %0d expected %0d (0=cfg 1=rd)", i, seq[i], exp_seq[i]);
      end
    end
    checks++;
    if (en_total != 4 || min_gap < 2 + GAP + 2) begin
      errors++; $display("FAIL rr_enable: got %0d cycles min gap %0d expected 4 and >= %0d", en_total, min_gap, 2 + GAP + 2);
    end
  endtask

  task automatic test_abort;
    run_burst(1'b0, 8'd10, 4);
    checks++;
    if (r_timeout !== 1'b0 || r_en_cnt != 5) begin
      errors++; $display("FAIL abort_enable: got timeout %b cycles %0d expected 0 5", r_timeout, r_en_cnt);
    end
    checks++;
    if (pulse_cnt !== 8'd2) begin errors++; $display("FAIL abort_count: got %0d expected 2", pulse_cnt); end
    checks++;
    if (r_done_cnt != 1 || r_done_ab !== 1'b1) begin
      errors++; $display("FAIL abort_flag: got done %0d aborted %b expected 1 1", r_done_cnt, r_done_ab);
    end
    checks++;
    if (r_done_cyc != r_en_last + 3) begin
      errors++; $display("FAIL abort_done: got cycle %0d expected %0d", r_done_cyc, r_en_last + 3);
    end
    run_burst(1'b1, 8'd1, 0);
    checks++;
    if (r_timeout !== 1'b0 || r_done_ab !== 1'b0) begin
      errors++; $display("FAIL abort_clear: got timeout %b aborted %b expected 0 0", r_timeout, r_done_ab);
    end
    checks++;
    if (r_en_cnt != 1 || pulse_cnt !== 8'd1) begin
      errors++; $display("FAIL abort_next: got cycles %0d pulse_cnt %0d expected 1 1", r_en_cnt, pulse_cnt);
    end
  endtask

  task automatic test_reset_mid;
    int n = 0, dones = 0, who = -1;
    logic got_done = 1'b0, went_idle = 1'b0;
    @(negedge clk);
    req_cfg = 1'b1; len_cfg = 8'd8;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (dp_enable) n++;
      if (n == 5) break;
    end
    checks++;
    if (n != 5) begin errors++; $display("FAIL rmid_start: got %0d enable cycles expected 5", n); end
    #2 reset = 1'b1; req_cfg = 1'b0;
    #1;
    checks++;
    if ({dp_enable, busy} !== 2'b00) begin
      errors++; $display("FAIL rmid_async: got enable,busy %b expected 00", {dp_enable, busy});
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (done_cfg | done_rd | busy) dones++;
    end
    checks++;
    if (dones != 0) begin errors++; $display("FAIL rmid_no_done: got %0d active cycles expected 0", dones); end
    reset = 1'b0;
    @(negedge clk);
    req_cfg = 1'b1; req_rd = 1'b1; len_cfg = 8'd2; len_rd = 8'd0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (gnt_cfg) begin who = 0; break; end
      if (gnt_rd) begin who = 1; break; end
    end
    req_rd = 1'b0;
    checks++;
    if (who != 0) begin errors++; $display("FAIL rmid_priority: got %0d expected 0 (0=cfg 1=rd)", who); end
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (done_cfg) begin got_done = 1'b1; req_cfg = 1'b0; break; end
    end
    req_cfg = 1'b0;
    checks++;
    if (got_done !== 1'b1 || pulse_cnt !== 8'd2) begin
      errors++; $display("FAIL rmid_serve: got done %b pulse_cnt %0d expected 1 2", got_done, pulse_cnt);
    end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (!busy) begin went_idle = 1'b1; break; end
    end
    checks++;
    if (went_idle !== 1'b1) begin errors++; $display("FAIL rmid_idle: got busy expected idle"); end
  endtask

  task automatic test_max_len;
    run_burst(1'b0, 8'd255, 0);
    checks++;
    if (r_timeout !== 1'b0 || r_en_cnt != 509) begin
      errors++; $display("FAIL max_enable: got timeout %b cycles %0d expected 0 509", r_timeout, r_en_cnt);
    end
    checks++;
    if (pulse_cnt !== 8'd255) begin errors++; $display("FAIL max_count: got %0d expected 255", pulse_cnt); end
    checks++;
    if (r_done_cyc != r_en_last + 3 || r_done_ab !== 1'b0) begin
      errors++; $display("FAIL max_done: got cycle %0d aborted %b expected %0d 0", r_done_cyc, r_done_ab, r_en_last + 3);
    end
  endtask

  initial begin
    test_reset;
    test_single_burst;
    test_zero_len;
    test_round_robin;
    test_abort;
    test_reset_mid;
    test_max_len;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
